cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
//  Parametrised run controller for the CPU core: sequences CPU reset, lets the CPU run,
//  and resumes it via continue pulses each time it halts, up to MAX_RESUMES times.
//  Provides a watchdog timeout, captures the debug bus at every halt, and reports done/pass
//  against an expected value. Sits between board/bench control and the CPU's rst/continue/halted pins.
// PARAMETERS
//  DW          32      width of cpu_debug / expect_debug / last_debug
//  CNT_W       32      width of cycle_count and the timeout comparator
//  RST_CYCLES  2       cycles cpu_rst is held high in RESET (>=1)
//  CONT_PULSE  1       cycles cpu_continue is held high per resume (>=1)
//  MAX_RESUMES 4       halts that are resumed; the halt after the last resume ends the run
//  TIMEOUT     100000  run cycles before the watchdog fires (>=2, < 2**CNT_W)
// PORTS
//  clk           in   1      clock, all logic on posedge
//  rst           in   1      synchronous active-high reset
//  start         in   1      1-cycle request to begin a run (honoured in IDLE/DONE/TOUT only)
//  cpu_halted    in   1      CPU halted level
//  cpu_debug     in   DW     CPU debug bus
//  expect_debug  in   DW     expected final debug value
//  cpu_rst       out  1      reset to CPU
//  cpu_continue  out  1      continue to CPU
//  busy          out  1      run in progress (RESET..WAIT_REL)
//  done          out  1      run finished (normal or timeout), held until next start/rst
//  timeout       out  1      watchdog fired, held with done
//  pass          out  1      done & ~timeout & (last_debug == expect_debug)
//  halt_count    out  8      halts seen this run, saturates at 255
//  cycle_count   out  CNT_W  cycles spent in RUN/WAIT_REL/CONT this run
//  last_debug    out  DW     cpu_debug sampled at the most recent halt
// BEHAVIOUR
//  States: IDLE, RESET, RUN, HALT, CONT, WAIT_REL, DONE, TOUT. All outputs registered.
//  - rst: state=IDLE; cpu_continue, busy, done, timeout, pass = 0; counters, last_debug = 0.
//    cpu_rst = 1 in the rst cycle, so the CPU is reset alongside; 0 in IDLE afterwards.
//  - IDLE/DONE/TOUT + start: clear counters, last_debug, done, timeout; go to RESET.
//    start in any other state is ignored.
//  - RESET: cpu_rst = 1 for exactly RST_CYCLES cycles, then RUN (cpu_rst = 0 on RUN entry).
//  - RUN: cycle_count += 1 each cycle. cpu_halted = 1 -> HALT; in the same edge, last_debug
//    <= cpu_debug and halt_count += 1 (saturating).
//  - HALT (1 cycle): resumes < MAX_RESUMES -> CONT, else DONE.
//  - CONT: cpu_continue = 1 for CONT_PULSE cycles; resumes += 1 on exit; then WAIT_REL.
//  - WAIT_REL: wait for cpu_halted = 0, then RUN. A halted level held past the pulse is
//    never counted twice.
//  - Watchdog: in RUN/CONT/WAIT_REL, cycle_count reaching TIMEOUT-1 -> TOUT next edge.
//    Halt in the same cycle as the timeout: halt wins (-> HALT), and the watchdog keeps
//    counting from the next active cycle.
//  - DONE: done = 1, pass per formula, busy = 0, cpu_continue = 0, CPU left halted.
//  - TOUT: done = 1, timeout = 1, pass = 0; last_debug holds the last halt capture.
//  - cycle_count freezes outside RUN/CONT/WAIT_REL; it never wraps because TOUT fires first.
//  - MAX_RESUMES = 0: the first halt goes straight to DONE.
//  - rst in any state aborts the run immediately with the reset values above.
// TESTING
//  1. rst, then start; CPU halts once at run cycle 10 with debug=0x0000_00AA, expect=0xAA,
//     MAX_RESUMES=0 -> cpu_rst high 2 cycles, done=1, pass=1, halt_count=1.
//  2. CPU halts 5 times with MAX_RESUMES=4 -> 4 continue pulses (1 cycle each), done after
//     halt 5, halt_count=5, last_debug = debug at the 5th halt.
//  3. CPU never halts, TIMEOUT=50 -> timeout=1, done=1, pass=0, cycle_count=50.
//  4. cpu_halted stays high 3 cycles after a continue pulse -> still one halt counted,
//     RUN re-entered when halted falls.
//  5. rst asserted mid-RUN -> next cycle all outputs at reset values, cpu_rst=1;
//     start pulsed while busy -> ignored.
//  6. Final debug=0x1234, expect=0x1235 -> done=1, pass=0, timeout=0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//   Run controller for the CPU core. It resets the CPU, lets it run, and each
//   time the CPU halts it resumes it with a continue pulse, up to MAX_RESUMES
//   times. A watchdog ends runs that stall. The debug bus is captured at every
//   halt and compared with an expected value once the run is done.
//
// Ports
//   clk           in   clock, all logic on posedge
//   rst           in   synchronous active-high reset
//   start         in   one-cycle run request, honoured in IDLE/DONE/TOUT only
//   cpu_halted    in   CPU halted level
//   cpu_debug     in   CPU debug bus [DW]
//   expect_debug  in   expected final debug value [DW]
//   cpu_rst       out  reset to the CPU
//   cpu_continue  out  continue pulse to the CPU
//   busy          out  run in progress
//   done          out  run finished (normal or watchdog)
//   timeout       out  watchdog fired
//   pass          out  done, no timeout, last_debug == expect_debug
//   halt_count    out  halts seen this run, saturating [8]
//   cycle_count   out  cycles spent in RUN/CONT/WAIT_REL this run [CNT_W]
//   last_debug    out  cpu_debug captured at the most recent halt [DW]
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int unsigned DW          = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned CONT_PULSE  = 1,
    parameter int unsigned MAX_RESUMES = 4,
    parameter int unsigned TIMEOUT     = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cpu_halted,
    input  logic [DW-1:0]    cpu_debug,
    input  logic [DW-1:0]    expect_debug,
    output logic             cpu_rst,
    output logic             cpu_continue,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             pass,
    output logic [7:0]       halt_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [DW-1:0]    last_debug
);

    localparam int unsigned RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned PC_W  = (CONT_PULSE > 1) ? $clog2(CONT_PULSE) : 1;
    localparam int unsigned RES_W = $clog2(MAX_RESUMES + 2);

    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(CONT_PULSE - 1);
    localparam logic [RES_W-1:0] RES_MAX  = RES_W'(MAX_RESUMES);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StReset, StRun, StHalt, StCont, StWaitRel, StDone, StTout
    } state_t;

    state_t           state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [PC_W-1:0]  pulse_cnt_q, pulse_cnt_d;
    logic [RES_W-1:0] resumes_q, resumes_d;
    logic [7:0]       halt_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_d;
    logic [DW-1:0]    last_dbg_d;
    logic             active;
    logic             wd_fire;

    // cycle_count sits at or past TIMEOUT-1 only after a halt beat the watchdog;
    // ">=" lets the watchdog fire on the next active cycle in that case.
    assign active  = (state_q == StRun) || (state_q == StCont) || (state_q == StWaitRel);
    assign wd_fire = (cycle_count >= TO_LAST);

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        resumes_d   = resumes_q;
        halt_cnt_d  = halt_count;
        cycle_cnt_d = cycle_count;
        last_dbg_d  = last_debug;

        // Saturate so an extreme TIMEOUT close to 2**CNT_W can never wrap.
        if (active && (cycle_count != '1)) begin
            cycle_cnt_d = cycle_count + 1'b1;
        end

        case (state_q)
            StIdle, StDone, StTout: begin
                if (start) begin
                    state_d     = StReset;
                    rst_cnt_d   = '0;
                    resumes_d   = '0;
                    halt_cnt_d  = '0;
                    cycle_cnt_d = '0;
                    last_dbg_d  = '0;
                end
            end
            StReset: begin
                if (rst_cnt_q == RC_LAST) begin
                    state_d = StRun;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            StRun: begin
                // A halt coinciding with the watchdog wins.
                if (cpu_halted) begin
                    state_d    = StHalt;
                    last_dbg_d = cpu_debug;
                    if (halt_count != 8'hFF) begin
                        halt_cnt_d = halt_count + 8'd1;
                    end
                end else if (wd_fire) begin
                    state_d = StTout;
                end
            end
            StHalt: begin
                if (resumes_q < RES_MAX) begin
                    state_d     = StCont;
                    pulse_cnt_d = '0;
                end else begin
                    state_d = StDone;
                end
            end
            StCont: begin
                if (wd_fire) begin
                    state_d = StTout;
                end else if (pulse_cnt_q == PC_LAST) begin
                    state_d   = StWaitRel;
                    resumes_d = resumes_q + 1'b1;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                end
            end
            StWaitRel: begin
                // Halted still high from the previous halt is not a new halt.
                if (wd_fire) begin
                    state_d = StTout;
                end else if (!cpu_halted) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rst_cnt_q    <= '0;
            pulse_cnt_q  <= '0;
            resumes_q    <= '0;
            halt_count   <= '0;
            cycle_count  <= '0;
            last_debug   <= '0;
            cpu_rst      <= 1'b1;
            cpu_continue <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            pass         <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            pulse_cnt_q  <= pulse_cnt_d;
            resumes_q    <= resumes_d;
            halt_count   <= halt_cnt_d;
            cycle_count  <= cycle_cnt_d;
            last_debug   <= last_dbg_d;
            // Outputs are a registered decode of the next state.
            cpu_rst      <= (state_d == StReset);
            cpu_continue <= (state_d == StCont);
            busy         <= (state_d != StIdle) && (state_d != StDone) && (state_d != StTout);
            done         <= (state_d == StDone) || (state_d == StTout);
            timeout      <= (state_d == StTout);
            pass         <= (state_d == StDone) && (last_dbg_d == expect_debug);
        end
    end

endmodule
